// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: funct3 codes and FSM state encoding.
package branch_resolver_pkg;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// Bundle of the execute-side branch request, fetch redirect handshake and status outputs.
interface branch_resolver_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             br_valid;
    logic             br_ready;
    logic [2:0]       br_funct3;
    logic             ne;
    logic             ge;
    logic [XLEN-1:0]  br_pc;
    logic [XLEN-1:0]  br_imm;
    logic             redirect_valid;
    logic             redirect_ready;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic             br_illegal;
    logic             br_misalign;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    modport slave (
        input  br_valid, br_funct3, ne, ge, br_pc, br_imm, redirect_ready,
        output br_ready, redirect_valid, redirect_pc, flush, br_illegal, br_misalign,
               branch_count, taken_count
    );

    modport master (
        output br_valid, br_funct3, ne, ge, br_pc, br_imm, redirect_ready,
        input  br_ready, redirect_valid, redirect_pc, flush, br_illegal, br_misalign,
               branch_count, taken_count
    );
endinterface

// File: rtl/branch_resolver_cond.sv
// Branch condition decoder: maps funct3 and comparator flags to taken/illegal.
module branch_cond
    import branch_resolver_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       ne,
    input  logic       ge,
    output logic       taken,
    output logic       illegal
);

    // Decode funct3 against the comparator flags
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = ~ne;
            F3_BNE:  taken = ne;
            F3_BLT:  taken = ~ge;
            F3_BGE:  taken = ge;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: decides taken/not-taken, issues a PC redirect to fetch, then flushes IF/ID.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic            clk,
    input  logic            reset,
    branch_resolver_if.slave bus
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    state_e           state_q, state_d;
    logic             br_ready_q, br_ready_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             flush_q, flush_d;
    logic [3:0]       flush_cnt_q, flush_cnt_d;
    logic             br_illegal_q, br_illegal_d;
    logic             br_misalign_q, br_misalign_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic            taken_s;
    logic            illegal_s;
    logic            accept_s;
    logic [XLEN-1:0] target_s;

    branch_cond u_cond (
        .funct3  (bus.br_funct3),
        .ne      (bus.ne),
        .ge      (bus.ge),
        .taken   (taken_s),
        .illegal (illegal_s)
    );

    assign accept_s = bus.br_valid & br_ready_q;
    assign target_s = bus.br_pc + bus.br_imm;

    // Next-state, output and counter computation
    always_comb begin
        state_d          = state_q;
        br_ready_d       = br_ready_q;
        redirect_valid_d = redirect_valid_q;
        redirect_pc_d    = redirect_pc_q;
        flush_d          = flush_q;
        flush_cnt_d      = flush_cnt_q;
        br_illegal_d     = 1'b0;
        br_misalign_d    = 1'b0;
        branch_count_d   = branch_count_q;
        taken_count_d    = taken_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    branch_count_d = sat_inc(branch_count_q);
                    if (illegal_s) begin
                        br_illegal_d = 1'b1;
                    end else if (taken_s && (target_s[1:0] != 2'b00)) begin
                        br_misalign_d = 1'b1;
                    end else if (taken_s) begin
                        state_d          = ST_REDIRECT;
                        br_ready_d       = 1'b0;
                        redirect_valid_d = 1'b1;
                        redirect_pc_d    = target_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) begin
                    state_d          = ST_FLUSH;
                    redirect_valid_d = 1'b0;
                    flush_d          = 1'b1;
                    flush_cnt_d      = FLUSH_INIT;
                    taken_count_d    = sat_inc(taken_count_q);
                end else begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_FLUSH: begin
                // The counter is preloaded with FLUSH_CYCLES-1 so flush spans exactly FLUSH_CYCLES
                if (flush_cnt_q == 4'd0) begin
                    state_d    = ST_IDLE;
                    flush_d    = 1'b0;
                    br_ready_d = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d          = ST_IDLE;
                br_ready_d       = 1'b1;
                redirect_valid_d = 1'b0;
                flush_d          = 1'b0;
                flush_cnt_d      = 4'd0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            br_ready_q       <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {XLEN{1'b0}};
            flush_q          <= 1'b0;
            flush_cnt_q      <= 4'd0;
            br_illegal_q     <= 1'b0;
            br_misalign_q    <= 1'b0;
            branch_count_q   <= {CNT_W{1'b0}};
            taken_count_q    <= {CNT_W{1'b0}};
        end else begin
            state_q          <= state_d;
            br_ready_q       <= br_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            flush_q          <= flush_d;
            flush_cnt_q      <= flush_cnt_d;
            br_illegal_q     <= br_illegal_d;
            br_misalign_q    <= br_misalign_d;
            branch_count_q   <= branch_count_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign bus.br_ready       = br_ready_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = flush_q;
    assign bus.br_illegal     = br_illegal_q;
    assign bus.br_misalign    = br_misalign_q;
    assign bus.branch_count   = branch_count_q;
    assign bus.taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed testbench for branch_resolver; a second small-counter instance covers saturation.
module tb_branch_resolver;

    logic clk;
    logic reset;
    int   total_q;
    int   bad_q;

    branch_resolver_if #(.XLEN(32), .CNT_W(16)) bi ();
    branch_resolver_if #(.XLEN(32), .CNT_W(4))  si ();

    branch_resolver #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bi)
    );

    branch_resolver #(.XLEN(32), .FLUSH_CYCLES(1), .CNT_W(4)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (si)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_q++;
        if (got !== exp) begin
            bad_q++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic n, input logic g,
                         input logic [31:0] pc, input logic [31:0] imm);
        bi.br_valid  = v;
        bi.br_funct3 = f3;
        bi.ne        = n;
        bi.ge        = g;
        bi.br_pc     = pc;
        bi.br_imm    = imm;
    endtask

    initial begin
        total_q = 0;
        bad_q   = 0;
        reset   = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 32'h0);
        bi.redirect_ready = 1'b0;
        si.br_valid  = 1'b0;
        si.br_funct3 = 3'b000;
        si.ne        = 1'b0;
        si.ge        = 1'b0;
        si.br_pc     = 32'h0;
        si.br_imm    = 32'h4;
        si.redirect_ready = 1'b1;
        step();
        step();
        chk("rst_ready", 32'(bi.br_ready), 32'd1);
        chk("rst_rvalid", 32'(bi.redirect_valid), 32'd0);
        chk("rst_rpc", bi.redirect_pc, 32'h0);
        chk("rst_flush", 32'(bi.flush), 32'd0);
        chk("rst_ill", 32'(bi.br_illegal), 32'd0);
        chk("rst_mis", 32'(bi.br_misalign), 32'd0);
        chk("rst_bcnt", 32'(bi.branch_count), 32'd0);
        chk("rst_tcnt", 32'(bi.taken_count), 32'd0);
        reset = 1'b0;

        // BEQ taken, fetch ready immediately
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h100, 32'h20);
        bi.redirect_ready = 1'b1;
        step();
        chk("beq_rvalid", 32'(bi.redirect_valid), 32'd1);
        chk("beq_rpc", bi.redirect_pc, 32'h120);
        chk("beq_ready", 32'(bi.br_ready), 32'd0);
        chk("beq_bcnt", 32'(bi.branch_count), 32'd1);
        bi.br_valid = 1'b0;
        step();
        chk("beq_rvalid_drop", 32'(bi.redirect_valid), 32'd0);
        chk("beq_flush1", 32'(bi.flush), 32'd1);
        chk("beq_tcnt", 32'(bi.taken_count), 32'd1);
        step();
        chk("beq_flush2", 32'(bi.flush), 32'd1);
        step();
        chk("beq_flush_end", 32'(bi.flush), 32'd0);
        chk("beq_ready_back", 32'(bi.br_ready), 32'd1);

        // BGE not taken
        drive(1'b1, 3'b101, 1'b0, 1'b0, 32'h300, 32'h10);
        step();
        chk("bge_ready", 32'(bi.br_ready), 32'd1);
        chk("bge_rvalid", 32'(bi.redirect_valid), 32'd0);
        chk("bge_bcnt", 32'(bi.branch_count), 32'd2);
        chk("bge_tcnt", 32'(bi.taken_count), 32'd1);
        bi.br_valid = 1'b0;
        step();
        chk("bge_flush", 32'(bi.flush), 32'd0);

        // BNE taken, fetch stalls 5 cycles while another branch waits upstream
        bi.redirect_ready = 1'b0;
        drive(1'b1, 3'b001, 1'b1, 1'b0, 32'h200, 32'h40);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bne_hold_valid", 32'(bi.redirect_valid), 32'd1);
            chk("bne_hold_pc", bi.redirect_pc, 32'h240);
            chk("bne_hold_ready", 32'(bi.br_ready), 32'd0);
            chk("bne_hold_bcnt", 32'(bi.branch_count), 32'd3);
            if (i < 4) step();
        end
        bi.redirect_ready = 1'b1;
        step();
        chk("bne_flush1", 32'(bi.flush), 32'd1);
        chk("bne_tcnt", 32'(bi.taken_count), 32'd2);
        step();
        chk("bne_flush2", 32'(bi.flush), 32'd1);
        step();
        chk("bne_idle", 32'(bi.br_ready), 32'd1);
        chk("bne_no_accept", 32'(bi.branch_count), 32'd3);
        bi.br_valid = 1'b0;

        // Illegal funct3
        drive(1'b1, 3'b010, 1'b0, 1'b1, 32'h100, 32'h20);
        step();
        chk("ill_pulse", 32'(bi.br_illegal), 32'd1);
        chk("ill_rvalid", 32'(bi.redirect_valid), 32'd0);
        chk("ill_bcnt", 32'(bi.branch_count), 32'd4);
        bi.br_valid = 1'b0;
        step();
        chk("ill_pulse_end", 32'(bi.br_illegal), 32'd0);

        // Taken with misaligned target
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h100, 32'h2);
        step();
        chk("mis_pulse", 32'(bi.br_misalign), 32'd1);
        chk("mis_rvalid", 32'(bi.redirect_valid), 32'd0);
        chk("mis_ready", 32'(bi.br_ready), 32'd1);
        chk("mis_bcnt", 32'(bi.branch_count), 32'd5);
        bi.br_valid = 1'b0;
        step();
        chk("mis_pulse_end", 32'(bi.br_misalign), 32'd0);
        chk("mis_tcnt", 32'(bi.taken_count), 32'd2);

        // Target wrap-around, then reset in FLUSH
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20);
        step();
        chk("wrap_rpc", bi.redirect_pc, 32'h0000_0010);
        chk("wrap_bcnt", 32'(bi.branch_count), 32'd6);
        bi.br_valid = 1'b0;
        step();
        chk("wrap_flush", 32'(bi.flush), 32'd1);
        chk("wrap_tcnt", 32'(bi.taken_count), 32'd3);
        reset = 1'b1;
        #1;
        chk("arst_flush", 32'(bi.flush), 32'd0);
        chk("arst_ready", 32'(bi.br_ready), 32'd1);
        chk("arst_bcnt", 32'(bi.branch_count), 32'd0);
        chk("arst_tcnt", 32'(bi.taken_count), 32'd0);
        step();
        reset = 1'b0;

        // BLT taken with negative offset
        drive(1'b1, 3'b100, 1'b1, 1'b0, 32'h1000, 32'hFFFF_FFF0);
        step();
        chk("blt_rvalid", 32'(bi.redirect_valid), 32'd1);
        chk("blt_rpc", bi.redirect_pc, 32'h0000_0FF0);
        chk("blt_bcnt", 32'(bi.branch_count), 32'd1);
        bi.br_valid = 1'b0;
        step();
        step();
        step();
        chk("blt_idle", 32'(bi.br_ready), 32'd1);

        // Saturation on the 4-bit-counter instance: 3 cycles per taken branch
        si.br_valid = 1'b1;
        for (int i = 0; i < 60; i++) step();
        chk("sat_bcnt", 32'(si.branch_count), 32'hF);
        chk("sat_tcnt", 32'(si.taken_count), 32'hF);
        for (int i = 0; i < 9; i++) step();
        chk("sat_bcnt_hold", 32'(si.branch_count), 32'hF);
        chk("sat_tcnt_hold", 32'(si.taken_count), 32'hF);
        si.br_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total_q, bad_q);
        $finish;
    end

endmodule
